// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder.
`default_nettype none
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle between a client and the bit-serial adder.
`default_nettype none
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface
`default_nettype wire

// File: rtl/serial_adder_fa.sv
// fa: one-bit full adder cell, the only arithmetic in the serial adder datapath.
`default_nettype none
module fa (
  input  wire A,
  input  wire B,
  input  wire Cin,
  output wire S,
  output wire Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);
endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first,
// through a single fa cell; result and carry-out are presented with a one-cycle done pulse.
`default_nettype none
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire           clk,
  input  wire           rst,
  serial_adder_if.slave bus
);
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] partial;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_s;
  logic             fa_cout;
  logic             last_bit;

  assign last_bit = (cnt == LAST);

  fa u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? SHIFT : IDLE;
      SHIFT:   state_nx = last_bit ? DONE : SHIFT;
      DONE:    state_nx = bus.start ? SHIFT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      partial <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx == SHIFT);
      done_q <= (state_nx == DONE);
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_sr    <= bus.a;
            b_sr    <= bus.b;
            carry_q <= bus.cin;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          // Partial sum holds WIDTH-1 bits; the final bit goes straight into the result.
          partial <= (WIDTH-1)'({fa_s, partial} >> 1);
          carry_q <= fa_cout;
          cnt     <= cnt + CW'(1);
          if (last_bit) begin
            sum_q  <= {fa_s, partial};
            cout_q <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and exhaustive checks of serial_adder against a cycle-level
// transaction model (8-bit) plus arithmetic checks at WIDTH=4.
`default_nettype none
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(4)) bus4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted add stays busy WIDTH cycles, then shows its result.
  int         rem   = 0;
  logic [8:0] pend  = '0;
  logic [8:0] m_res = '0;
  logic       m_done = 1'b0;
  logic       chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      rem = 0; m_done = 1'b0; m_res = '0;
    end else if (rem > 0) begin
      rem--;
      m_done = (rem == 0);
      if (rem == 0) m_res = pend;
    end else begin
      m_done = 1'b0;
      if (bus8.start) begin
        pend = 9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin);
        rem  = 8;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", bus8.busy, rem > 0);
      check("model_done", bus8.done, m_done);
      check("model_result", {bus8.cout, bus8.sum}, m_res);
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] esum, input logic ecout);
    int busy_cnt = 0;
    logic seen = 1'b0;
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus8.done) begin seen = 1'b1; break; end
      if (bus8.busy) busy_cnt++;
      @(negedge clk);
    end
    check("op_done_seen", seen, 1'b1);
    check("op_sum", bus8.sum, esum);
    check("op_cout", bus8.cout, ecout);
    check("op_busy_cycles", busy_cnt, 8);
    @(negedge clk);
  endtask

  task automatic count_dones8(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus8.done) n++;
    end
  endtask

  initial begin
    int n;
    int t_prev;
    int n_done;
    logic seen;
    logic [4:0] last4;
    logic [4:0] exp4;

    rst = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", bus8.busy, 1'b0);
    check("reset_done", bus8.done, 1'b0);
    check("reset_sum", bus8.sum, 8'h00);
    check("reset_cout", bus8.cout, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;

    op8(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start pulsed mid-SHIFT must be ignored.
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus8.done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("ignore_done_seen", seen, 1'b1);
    check("ignore_sum", bus8.sum, 8'h30);
    check("ignore_cout", bus8.cout, 1'b0);
    count_dones8(15, n);
    check("ignore_no_second_op", n, 0);

    // Back-to-back with start held high.
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 1'b0; bus8.start = 1'b1;
    n_done = 0; t_prev = -1;
    for (int c = 0; c < 60 && n_done < 3; c++) begin
      @(negedge clk);
      if (bus8.done) begin
        check("held_sum", bus8.sum, 8'h00);
        check("held_cout", bus8.cout, 1'b1);
        if (t_prev >= 0) check("held_period", c - t_prev, 9);
        t_prev = c;
        n_done++;
      end
    end
    check("held_done_count", n_done, 3);
    bus8.start = 1'b0;
    @(negedge clk);

    // Reset during the 4th SHIFT cycle aborts the add.
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", bus8.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus8.busy, 1'b0);
    check("abort_done", bus8.done, 1'b0);
    check("abort_sum", bus8.sum, 8'h00);
    check("abort_cout", bus8.cout, 1'b0);
    count_dones8(15, n);
    check("abort_no_done", n, 0);
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // Exhaustive sweep at WIDTH=4 with result-hold checking between completions.
    last4 = '0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          bus4.a = 4'(ia); bus4.b = 4'(ib); bus4.cin = 1'(ic); bus4.start = 1'b1;
          exp4 = 5'(ia + ib + ic);
          @(negedge clk);
          bus4.start = 1'b0;
          seen = 1'b0;
          for (int i = 0; i < 12; i++) begin
            if (bus4.done) begin seen = 1'b1; break; end
            if ({bus4.cout, bus4.sum} !== last4)
              check("w4_hold", {bus4.cout, bus4.sum}, last4);
            @(negedge clk);
          end
          check("w4_done_seen", seen, 1'b1);
          check("w4_result", {bus4.cout, bus4.sum}, exp4);
          last4 = exp4;
          @(negedge clk);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that sits directly upstream of the one-bit full adder `fa` and drives it. It accepts two WIDTH-bit operands plus a carry-in on a start pulse and presents one bit pair per clock, LSB first, to a single `fa` instance. The carry is registered between cycles. The block returns the full sum and carry-out with a one-cycle done pulse. It trades WIDTH cycles of latency for one adder cell, as the lab datapath's area-minimal add unit.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result registers just updated.
- sum  output  WIDTH  registered result; held until next completion.
- cout  output  1  registered carry-out; held until next completion.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 → capture a, b into operand shift registers, cin into carry flop, clear bit counter, go to SHIFT. If start=0, stay.
- SHIFT, each edge:
  - `fa` inputs are A=a_sr[0], B=b_sr[0], Cin=carry_q.
  - Shift a_sr and b_sr right by 1.
  - Shift fa.S into MSB of internal partial-sum register.
  - carry_q <= fa.Cout; counter++.
- The edge processing bit WIDTH-1 loads sum <= {S, partial[WIDTH-1:1]} and cout <= fa.Cout, then goes to DONE.
- DONE lasts exactly one cycle, with done=1. start=1 here is accepted exactly as in IDLE and goes to SHIFT. Otherwise go to IDLE.
- start while in SHIFT is ignored. Operand inputs a, b, cin are don't-care except at the accepting edge.
- sum/cout never show partial results. They change only at the completion edge or on reset.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Bit counter width: $clog2(WIDTH). Completion is detected when counter == WIDTH-1.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry_q and counter cleared.
  - rst dominates start.
- Reset mid-SHIFT aborts the operation: no done pulse, outputs zeroed.
- Accepting start at edge k → busy=1 from k until edge k+WIDTH.
- Result becomes valid and done=1 after edge k+WIDTH, for one cycle.
- done and busy are never high together.
- Throughput is one addition per WIDTH+1 cycles when start is held high continuously. Each DONE cycle re-accepts start.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package serial_adder_pkg:
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE}.
  - Default WIDTH localparam.
- Sub-module: one instance of the existing `fa` (ports A, B, Cin, S, Cout). No other adder logic is inferred in this block.
- Pieces:
  - FSM with a next-state always_comb.
  - Datapath always_ff for shift registers, carry, counter and result registers.

## Test plan
- WIDTH=8; start with a=8'h3C, b=8'h5A, cin=0 → after 8 edges, done=1 for 1 cycle, sum=8'h96, cout=0; busy high for exactly 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Pulse start=1 with new operands (a=8'h01, b=8'h01) during SHIFT of a 8'h10+8'h20 add → ignored; result 8'h30, cout=0; no second operation.
- Hold start=1 continuously with a=8'h80, b=8'h80, cin=0 → done every 9 cycles, each time sum=8'h00, cout=1; busy low only in DONE cycles.
- Assert rst at the 4th SHIFT cycle of 8'hAA+8'h55 → next cycle busy=0, done=0, sum=0, cout=0, and no done afterward. A subsequent start with 8'h01+8'h02 → sum=8'h03.
- Exhaustive check at WIDTH=4, all a, b, cin combinations (512 cases): {cout, sum} == a+b+cin, and sum/cout stable between done pulses.
